// File: rtl/tdm_pkg.sv
// Shared TDM constants and FSM encodings for the transmit mux and receive demux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tdm_pkg;

  localparam int NSLOT  = 8;   // channel slots per frame
  localparam int SLOT_W = 3;   // bits needed to index a slot

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux1x8.sv
// 1-to-8 write-enable decoder: inverse of the transmit-side 8-to-1 slot selector.
// Latency: combinational, zero cycles.
// Backpressure: none; valid low forces every enable low.
//
// Ports:
//   slot  - slot index to enable
//   valid - qualifies the decode
//   we    - one-hot write enable, all zero when valid is low
module demux1x8
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  input  logic              valid,
  output logic [NSLOT-1:0]  we
);

  always_comb begin
    we = '0;
    if (valid) begin
      we[slot] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer: steers serial slot beats into a shadow bank and
// presents each complete 8-slot frame as one parallel word. Latency: 1 cycle from
// the slot-7 beat to dout/dout_valid. Backpressure: none; beats are taken whenever din_valid is high.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   din, din_valid    - slot data beat and its qualifier
//   frame_sync        - marks the beat as slot 0 (qualified by din_valid)
//   dout, dout_valid  - last complete frame and its one-cycle update strobe
//   slot              - slot the next accepted beat lands in
//   locked            - frame alignment acquired
//   sync_err          - one-cycle strobe: frame_sync arrived mid-frame
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [8*W-1:0]    dout,
  output logic              dout_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
);

  state_t                state;
  logic [W-1:0]          shadow [NSLOT];
  logic                  accept;
  logic [SLOT_W-1:0]     wr_slot;
  logic [NSLOT-1:0]      wr_en;
  logic                  frame_done;
  logic [NSLOT*W-1:0]    frame_word;

  // In HUNT only a frame_sync beat is taken; in LOCKED every valid beat is.
  assign accept = din_valid && ((state == ST_LOCKED) || frame_sync);

  // A frame_sync beat always lands in slot 0, which is also how a mid-frame
  // resync realigns without going back to HUNT.
  assign wr_slot = frame_sync ? '0 : slot;

  // A resync beat sitting at slot 7 must not complete the discarded frame.
  assign frame_done = accept && !frame_sync && (slot == SLOT_W'(NSLOT - 1));

  demux1x8 u_demux (
    .slot  (wr_slot),
    .valid (accept),
    .we    (wr_en)
  );

  // The slot-7 beat bypasses the shadow bank so dout loads in the same edge.
  always_comb begin
    frame_word = '0;
    for (int i = 0; i < NSLOT - 1; i++) begin
      frame_word[i*W +: W] = shadow[i];
    end
    frame_word[(NSLOT-1)*W +: W] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      locked     <= 1'b0;
      slot       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      dout_valid <= frame_done;
      sync_err   <= 1'b0;

      for (int i = 0; i < NSLOT; i++) begin
        if (wr_en[i]) begin
          shadow[i] <= din;
        end
      end

      if (frame_done) begin
        dout <= frame_word;
      end

      case (state)
        ST_HUNT: begin
          if (din_valid && frame_sync) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
            slot   <= SLOT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (din_valid) begin
            if (frame_sync) begin
              sync_err <= (slot != '0);
              slot     <= SLOT_W'(1);
            end else begin
              slot <= slot + SLOT_W'(1);
            end
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
          slot   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8 (W=1): per-beat vector table plus a frame scoreboard.
// Latency: expects dout/dout_valid one cycle after the slot-7 beat.
// Backpressure: n/a; stimulus drives din_valid directly.
module tb_tdm_demux8;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  tdm_demux8 #(.W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs, then expected outputs after the edge.
  typedef struct {
    logic       r;
    logic       v;
    logic       fs;
    logic       d;
    logic [2:0] es;
    logic       el;
    logic       ee;
    logic       push;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } exp_t;

  vec_t       vecs[$];
  exp_t       exp_q[$];
  exp_t       exp_e;
  logic [7:0] last_frame;
  int         cyc;
  int         checks;
  int         failures;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic fs, input logic d,
                     input logic [2:0] es, input logic el, input logic ee, input logic push);
    vec_t t;
    t.r = r; t.v = v; t.fs = fs; t.d = d;
    t.es = es; t.el = el; t.ee = ee; t.push = push;
    t.ed = last_frame;
    vecs.push_back(t);
  endtask

  // Eight beats of val (bit i in slot i), frame_sync on the first beat.
  // gaps inserts an idle cycle (with frame_sync high, which must be ignored) after each beat.
  task automatic add_frame(input logic [7:0] val, input logic err0, input logic gaps);
    logic [2:0] es;
    for (int i = 0; i < 8; i++) begin
      es = 3'(i + 1);
      if (i == 7) last_frame = val;
      add(1'b0, 1'b1, (i == 0), val[i], es, 1'b1, (i == 0) && err0, (i == 7));
      if (gaps) add(1'b0, 1'b0, 1'b1, 1'b1, es, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Scoreboard: every dout_valid must match the next expected frame and cycle.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dout_valid: got dout_valid=1 dout=%0h want no strobe (cycle %0d)", dout, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        chk("strobe_cycle", cyc, exp_e.cyc);
        chk("frame_dout", {24'd0, dout}, {24'd0, exp_e.dat});
      end
    end
  end

  initial begin
    cyc        = 0;
    checks     = 0;
    failures   = 0;
    last_frame = 8'h00;
    rst        = 1'b1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 1'b0;

    // Reset, then beats without frame_sync are dropped in HUNT.
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    // First frame 1,0,1,1,0,0,1,0 from HUNT.
    add_frame(8'h4D, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    // Back-to-back frames at full rate.
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'h3C, 1'b0, 1'b0);
    // Valid toggling across a frame.
    add_frame(8'hF0, 1'b0, 1'b1);
    // Five garbage beats, then frame_sync at slot 5 realigns.
    for (int k = 1; k <= 5; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 3'(k), 1'b1, 1'b0, 1'b0);
    add_frame(8'h96, 1'b1, 1'b0);
    // Partial frame to slot 4, then reset (with a live beat) discards it.
    add(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 3'(k), 1'b1, 1'b0, 1'b0);
    last_frame = 8'h00;
    add(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    // A full frame without frame_sync after reset stays in HUNT.
    for (int k = 0; k < 8; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      rst        = vecs[n].r;
      din_valid  = vecs[n].v;
      frame_sync = vecs[n].fs;
      din        = vecs[n].d;
      if (vecs[n].push) begin
        exp_e.cyc = cyc + 1;
        exp_e.dat = vecs[n].ed;
        exp_q.push_back(exp_e);
      end
      @(negedge clk);
      chk($sformatf("slot[%0d]", n), {29'd0, slot}, {29'd0, vecs[n].es});
      chk($sformatf("locked[%0d]", n), {31'd0, locked}, {31'd0, vecs[n].el});
      chk($sformatf("sync_err[%0d]", n), {31'd0, sync_err}, {31'd0, vecs[n].ee});
      chk($sformatf("dout_hold[%0d]", n), {24'd0, dout}, {24'd0, vecs[n].ed});
      if (vecs[n].r) begin
        chk($sformatf("reset_dout_valid[%0d]", n), {31'd0, dout_valid}, 32'd0);
      end
    end

    rst        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
